sum_of_squares_acc: RTL and testbench
=====================================

SUM_OF_SQUARES_ACC -- requirements
Module: sum_of_squares_acc

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, number of squarer results summed per frame; legal range 2..256.
REQ-002 SHALL have parameter ACC_W, default 24, accumulator and output sum width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port y_in  input  16  squarer result Y from squarer_8bit.
REQ-006 SHALL have port in_valid  input  1  y_in valid.
REQ-007 SHALL have port in_ready  output  1  block accepts y_in this cycle.
REQ-008 SHALL have port clear  input  1  synchronous discard of the partial frame.
REQ-009 SHALL have port out_sum  output  ACC_W  completed frame sum.
REQ-010 SHALL have port out_idx  output  8  frame index of out_sum, wraps 255->0.
REQ-011 SHALL have port out_valid  output  1  out_sum/out_idx valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts output this cycle.

Function
REQ-013 SHALL perform input transfer on a rising edge with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-014 SHALL implement FSM states ACCUM, STALL; in_ready = (state==ACCUM) && !clear, no other dependency.
REQ-015 SHALL, in ACCUM, add zero-extended y_in to acc and increment count (0..FRAME_LEN-1) per input transfer.
REQ-016 SHALL, on transfer of the FRAME_LEN-th sample with output register free (out_valid==0) or freed this cycle (out_ready==1), load out_sum=acc+y_in, out_idx=frame_cnt, out_valid=1 next cycle, reset acc/count to 0, increment frame_cnt, stay ACCUM.
REQ-017 SHALL, on that transfer with out_valid==1 and out_ready==0, hold acc+y_in in acc and enter STALL.
REQ-018 SHALL, in STALL, load out_sum from acc on the cycle out_ready is high, clear acc/count, increment frame_cnt, return to ACCUM; out_valid stays 1.
REQ-019 SHALL clear out_valid after an output transfer unless a new sum loads the same edge.
REQ-020 SHALL keep out_sum/out_idx stable while out_valid && !out_ready.
REQ-021 SHALL, on clear, zero acc and count and go to ACCUM (discarding a held STALL sum); pending output register, out_valid and frame_cnt untouched; sample presented with clear is not accepted.
REQ-022 SHALL give latency of one cycle from last-sample transfer edge to out_valid (no stall).
REQ-023 SHALL sustain one sample per cycle indefinitely when out_ready is held high.
REQ-024 SHALL require ACC_W >= 16+clog2(FRAME_LEN); elaboration error otherwise; no overflow or saturation logic.
REQ-025 SHALL ignore the squarer garbage outputs entirely.

Reset
REQ-026 SHALL, on rst_n low, asynchronously set state=ACCUM, acc=0, count=0, frame_cnt=0, out_sum=0, out_idx=0, out_valid=0; in_ready reads 1 while clear=0.
REQ-027 SHALL discard any partial or held frame on reset mid-operation; first frame after reset has out_idx=0.

Structure
REQ-028 SHALL place the FSM state enumeration and the ACC_W width-check helper (clog2-based minimum width) in the shared package sqr_pkg.
REQ-029 SHALL be a single module without sub-modules; the testbench instantiates squarer_8bit upstream driving y_in.

Verification
REQ-030 SHALL cover basic frame: FRAME_LEN=4, a=15,15,15,15 back-to-back, out_ready=1 -> out_sum=900, out_idx=0, out_valid one cycle after 4th transfer.
REQ-031 SHALL cover max values: FRAME_LEN=4, a=255 x4 -> out_sum=260100 (0x03F804); default FRAME_LEN=16, a=255 x16 -> 1040400.
REQ-032 SHALL cover stall: out_ready=0, two frames of a=1 (FRAME_LEN=4) -> STALL, in_ready=0; out_ready=1 for one cycle -> out_sum=4 idx0 transferred, next output out_sum=4 idx1, in_ready returns 1.
REQ-033 SHALL cover clear: two samples a=10, clear, then four a=2 -> out_sum=16, out_idx=0.
REQ-034 SHALL cover wrap: 257 frames with out_ready=1 -> out_idx sequence 0..255,0.
REQ-035 SHALL cover reset mid-frame: rst_n low after 3 of 4 samples -> out_valid=0, then four a=3 -> out_sum=36, out_idx=0.

Source files
------------

// File: rtl/sqr_pkg.sv
// Shared definitions for the sum-of-squares datapath.
//   state_t   : accumulator FSM states (ACCUM, STALL)
//   min_acc_w : minimum accumulator width that cannot overflow for a
//               given frame length of 16-bit squarer results
package sqr_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam int unsigned SQR_W = 16;

  function automatic int unsigned min_acc_w(input int unsigned frame_len);
    return SQR_W + $clog2(frame_len);
  endfunction

endpackage

// File: rtl/squarer_8bit.sv
// Combinational 8-bit squarer feeding the sum-of-squares accumulator.
//   a       : 8-bit unsigned operand
//   y       : 16-bit square a*a
//   garbage : diagnostic bits with no meaning downstream
module squarer_8bit (
  input  logic [7:0]  a,
  output logic [15:0] y,
  output logic [7:0]  garbage
);

  always_comb begin
    y       = 16'(a) * 16'(a);
    garbage = y[15:8] ^ a;
  end

endmodule

// File: rtl/sum_of_squares_acc.sv
// Frame accumulator for squarer results.
// Sums FRAME_LEN consecutive y_in transfers and presents the total on a
// valid/ready output together with a wrapping 8-bit frame index.
//   clk, rst_n          : clock, asynchronous active-low reset
//   y_in/in_valid/      : squarer result input handshake
//   in_ready
//   clear               : synchronous discard of the partial/held frame
//   out_sum/out_idx/    : completed frame sum and index, output handshake
//   out_valid/out_ready
module sum_of_squares_acc
  import sqr_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned ACC_W     = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      y_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_idx,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN);

  if (FRAME_LEN < 2 || FRAME_LEN > 256) begin : g_bad_frame_len
    $error("sum_of_squares_acc: FRAME_LEN must be within 2..256");
  end

  if (ACC_W < min_acc_w(FRAME_LEN)) begin : g_bad_acc_w
    $error("sum_of_squares_acc: ACC_W too narrow for FRAME_LEN");
  end

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [7:0]       frame_cnt;

  logic             in_xfer;
  logic             out_xfer;
  logic             last;
  logic [ACC_W-1:0] sum_next;

  always_comb begin
    in_ready = (state == ACCUM) && !clear;
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
    last     = (count == CNT_W'(FRAME_LEN - 1));
    sum_next = acc + ACC_W'(y_in);
  end

  // Output register and frame state are updated in one block: a new sum
  // may load on the same edge the previous one transfers, so out_valid
  // only drops when nothing loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      frame_cnt <= '0;
      out_sum   <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_xfer) begin
        out_valid <= 1'b0;
      end

      if (clear) begin
        state <= ACCUM;
        acc   <= '0;
        count <= '0;
      end else begin
        case (state)
          ACCUM: begin
            if (in_xfer) begin
              if (!last) begin
                acc   <= sum_next;
                count <= count + 1'b1;
              end else if (!out_valid || out_ready) begin
                out_sum   <= sum_next;
                out_idx   <= frame_cnt;
                out_valid <= 1'b1;
                frame_cnt <= frame_cnt + 1'b1;
                acc       <= '0;
                count     <= '0;
              end else begin
                acc   <= sum_next;
                state <= STALL;
              end
            end
          end
          STALL: begin
            // out_valid is necessarily 1 here; the held frame replaces the
            // one transferring on this edge.
            if (out_ready) begin
              out_sum   <= acc;
              out_idx   <= frame_cnt;
              out_valid <= 1'b1;
              frame_cnt <= frame_cnt + 1'b1;
              acc       <= '0;
              count     <= '0;
              state     <= ACCUM;
            end
          end
          default: state <= ACCUM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sum_of_squares_acc.sv
module tb_sum_of_squares_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a;
  logic [15:0] y;
  logic        in_valid;
  logic        clear;
  logic        out_ready;

  logic        in_ready4, out_valid4;
  logic [23:0] out_sum4;
  logic [7:0]  out_idx4;
  logic        in_ready16, out_valid16;
  logic [23:0] out_sum16;
  logic [7:0]  out_idx16;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  squarer_8bit u_sqr (
    .a       (a),
    .y       (y),
    .garbage ()
  );

  sum_of_squares_acc #(.FRAME_LEN(4), .ACC_W(24)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .y_in      (y),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .clear     (clear),
    .out_sum   (out_sum4),
    .out_idx   (out_idx4),
    .out_valid (out_valid4),
    .out_ready (out_ready)
  );

  sum_of_squares_acc #(.FRAME_LEN(16), .ACC_W(24)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .y_in      (y),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .clear     (clear),
    .out_sum   (out_sum16),
    .out_idx   (out_idx16),
    .out_valid (out_valid16),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    clear     = 1'b0;
    a         = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  // Present n back-to-back samples of value v, one transfer per cycle.
  task automatic feed(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      a        = v;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    a         = '0;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    #3;
    check("rst_out_valid", 32'(out_valid4), 32'd0);
    check("rst_out_sum",   32'(out_sum4),   32'd0);
    check("rst_out_idx",   32'(out_idx4),   32'd0);
    check("rst_in_ready",  32'(in_ready4),  32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic frame: 15^2 * 4 = 900
    feed(8'd15, 3);
    check("basic_not_yet", 32'(out_valid4), 32'd0);
    feed(8'd15, 1);
    check("basic_valid", 32'(out_valid4), 32'd1);
    check("basic_sum",   32'(out_sum4),   32'd900);
    check("basic_idx",   32'(out_idx4),   32'd0);
    tick();
    check("basic_drained", 32'(out_valid4), 32'd0);

    // Max values: 255^2 * 4 = 260100, frame index 1
    feed(8'd255, 4);
    check("max4_sum", 32'(out_sum4), 32'd260100);
    check("max4_idx", 32'(out_idx4), 32'd1);

    // Stall: two frames of a=1 with out_ready low
    do_reset();
    out_ready = 1'b0;
    feed(8'd1, 4);
    check("stall_f0_valid", 32'(out_valid4), 32'd1);
    check("stall_f0_sum",   32'(out_sum4),   32'd4);
    feed(8'd1, 4);
    check("stall_in_ready", 32'(in_ready4), 32'd0);
    tick();
    check("stall_hold_sum", 32'(out_sum4), 32'd4);
    check("stall_hold_idx", 32'(out_idx4), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_f1_valid", 32'(out_valid4), 32'd1);
    check("stall_f1_sum",   32'(out_sum4),   32'd4);
    check("stall_f1_idx",   32'(out_idx4),   32'd1);
    check("stall_ready_back", 32'(in_ready4), 32'd1);
    out_ready = 1'b1;
    tick();
    check("stall_drained", 32'(out_valid4), 32'd0);

    // Clear: partial frame of 10s discarded, sample presented with clear dropped
    do_reset();
    feed(8'd10, 2);
    a        = 8'd10;
    in_valid = 1'b1;
    clear    = 1'b1;
    #1;
    check("clear_in_ready", 32'(in_ready4), 32'd0);
    tick();
    clear    = 1'b0;
    feed(8'd2, 3);
    check("clear_not_yet", 32'(out_valid4), 32'd0);
    feed(8'd2, 1);
    check("clear_sum", 32'(out_sum4), 32'd16);
    check("clear_idx", 32'(out_idx4), 32'd0);

    // Index wrap across 257 frames
    do_reset();
    for (int f = 0; f < 257; f++) begin
      feed(8'd1, 4);
      check("wrap_idx", 32'(out_idx4), 32'(f % 256));
    end
    check("wrap_sum", 32'(out_sum4), 32'd4);

    // Reset mid-frame
    do_reset();
    feed(8'd5, 3);
    rst_n = 1'b0;
    #2;
    check("midrst_valid", 32'(out_valid4), 32'd0);
    check("midrst_in_ready", 32'(in_ready4), 32'd1);
    #2;
    rst_n = 1'b1;
    tick();
    feed(8'd3, 4);
    check("midrst_sum", 32'(out_sum4), 32'd36);
    check("midrst_idx", 32'(out_idx4), 32'd0);

    // Default frame length: 255^2 * 16 = 1040400
    do_reset();
    feed(8'd255, 15);
    check("max16_not_yet", 32'(out_valid16), 32'd0);
    feed(8'd255, 1);
    check("max16_valid", 32'(out_valid16), 32'd1);
    check("max16_sum",   32'(out_sum16),   32'd1040400);
    check("max16_idx",   32'(out_idx16),   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
